// File: rtl/phase_request_scheduler_pkg.sv
// traffic_phase_pkg: shared definitions for the phase request scheduler.
//   phase_e  - phase encodings (0 SS straight, 1 SS turn, 2 CS straight, 3 CS turn)
//   state_e  - scheduler FSM states
//   MAX_PHASE_CYCLES_DEFAULT - default active-phase watchdog limit
//   rr_next  - round-robin index helper
package traffic_phase_pkg;

  typedef enum logic [1:0] {
    PH_SS_STRAIGHT = 2'd0,
    PH_SS_TURN     = 2'd1,
    PH_CS_STRAIGHT = 2'd2,
    PH_CS_TURN     = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int unsigned MAX_PHASE_CYCLES_DEFAULT = 1000;

  // Phase index 'off' steps after 'base', wrapping modulo 4.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input int unsigned off);
    return base + off[1:0];
  endfunction

endpackage

// File: rtl/phase_request_scheduler_if.sv
// phase_request_scheduler_if: request/grant bundle between the intersection
// sensors, the light sequencer and the phase request scheduler.
//   slave  modport - scheduler side (sensors, buttons, phase_done in; grant out)
//   master modport - environment side (drives sensors, observes grant)
interface phase_request_scheduler_if;

  logic       straight_street_straight_lane_car_sensor;
  logic       straight_street_turn_lane_car_sensor;
  logic       cross_street_straight_lane_car_sensor;
  logic       cross_street_turn_lane_car_sensor;
  logic       straight_street_pedestrian_button;
  logic       cross_street_pedestrian_button;
  logic       phase_done;
  logic       phase_valid;
  logic [1:0] phase_select;
  logic       walk_enable;
  logic [3:0] pending_requests;
  logic       phase_timeout;

  modport slave (
    input  straight_street_straight_lane_car_sensor,
    input  straight_street_turn_lane_car_sensor,
    input  cross_street_straight_lane_car_sensor,
    input  cross_street_turn_lane_car_sensor,
    input  straight_street_pedestrian_button,
    input  cross_street_pedestrian_button,
    input  phase_done,
    output phase_valid,
    output phase_select,
    output walk_enable,
    output pending_requests,
    output phase_timeout
  );

  modport master (
    output straight_street_straight_lane_car_sensor,
    output straight_street_turn_lane_car_sensor,
    output cross_street_straight_lane_car_sensor,
    output cross_street_turn_lane_car_sensor,
    output straight_street_pedestrian_button,
    output cross_street_pedestrian_button,
    output phase_done,
    input  phase_valid,
    input  phase_select,
    input  walk_enable,
    input  pending_requests,
    input  phase_timeout
  );

endinterface

// File: rtl/phase_request_scheduler_picker.sv
// round_robin_picker_4: combinational 4-way round-robin selector.
//   request    [3:0] in  - per-phase request vector
//   last_phase [1:0] in  - most recently granted phase
//   pick       [1:0] out - first requesting phase after last_phase (wrapping)
//   found            out - at least one request is present
module round_robin_picker_4
  import traffic_phase_pkg::*;
(
  input  logic [3:0] request,
  input  logic [1:0] last_phase,
  output logic [1:0] pick,
  output logic       found
);

  logic [1:0] cand;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= 4; off++) begin
      cand = rr_next(last_phase, off);
      if (!found && request[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_request_scheduler.sv
// phase_request_scheduler: latches car/pedestrian requests for four signal
// phases and grants them one at a time in round-robin order to the light
// sequencer, with a watchdog that forces release of a stuck phase.
//   clk      in - system clock, rising edge
//   reset_n  in - asynchronous active-low reset
//   bus      slave modport of phase_request_scheduler_if:
//            sensors/buttons/phase_done in; phase_valid, phase_select,
//            walk_enable, pending_requests, phase_timeout out
module phase_request_scheduler
  import traffic_phase_pkg::*;
#(
  parameter int unsigned MAX_PHASE_CYCLES = MAX_PHASE_CYCLES_DEFAULT
) (
  input logic                     clk,
  input logic                     reset_n,
  phase_request_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_PHASE_CYCLES > 1) ? $clog2(MAX_PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PHASE_CYCLES - 1);

  state_e           state_q;
  phase_e           last_q;
  phase_e           sel_q;
  logic             valid_q;
  logic             walk_en_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       car_q, car_d;
  logic [1:0]       walk_q, walk_d;   // [0] straight street, [1] cross street

  logic [3:0] car_in, car_mask, eff_req;
  logic [1:0] walk_in, walk_mask;
  logic [1:0] pick;
  logic       found;
  logic       grant;
  logic       pick_walk;

  assign car_in  = {bus.cross_street_turn_lane_car_sensor,
                    bus.cross_street_straight_lane_car_sensor,
                    bus.straight_street_turn_lane_car_sensor,
                    bus.straight_street_straight_lane_car_sensor};
  assign walk_in = {bus.cross_street_pedestrian_button,
                    bus.straight_street_pedestrian_button};

  // Pedestrian requests ride on the straight-lane phase of their street.
  assign eff_req = {car_q[3], car_q[2] | walk_q[1], car_q[1], car_q[0] | walk_q[0]};

  round_robin_picker_4 u_picker (
    .request    (eff_req),
    .last_phase (last_q),
    .pick       (pick),
    .found      (found)
  );

  assign grant = (state_q == ST_IDLE) && found;

  // Grant decisions use only already-latched requests; a request sampled on
  // the grant edge for the granted phase is absorbed by that grant.
  always_comb begin
    car_mask  = '1;
    walk_mask = '1;
    if (state_q == ST_ACTIVE) begin
      car_mask[sel_q] = 1'b0;
      if (sel_q == PH_SS_STRAIGHT) walk_mask[0] = 1'b0;
      if (sel_q == PH_CS_STRAIGHT) walk_mask[1] = 1'b0;
    end
    car_d     = car_q | (car_in & car_mask);
    walk_d    = walk_q | (walk_in & walk_mask);
    pick_walk = 1'b0;
    if (grant) begin
      car_d[pick] = 1'b0;
      if (pick == 2'd0) begin
        pick_walk = walk_q[0];
        walk_d[0] = 1'b0;
      end
      if (pick == 2'd2) begin
        pick_walk = walk_q[1];
        walk_d[1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= PH_CS_TURN;
      sel_q     <= PH_SS_STRAIGHT;
      valid_q   <= 1'b0;
      walk_en_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      car_q     <= '0;
      walk_q    <= '0;
    end else begin
      car_q  <= car_d;
      walk_q <= walk_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q   <= ST_ACTIVE;
            valid_q   <= 1'b1;
            sel_q     <= phase_e'(pick);
            last_q    <= phase_e'(pick);
            walk_en_q <= pick_walk;
            cnt_q     <= '0;
          end
        end
        ST_ACTIVE: begin
          if (bus.phase_done) begin
            state_q   <= ST_RELEASE;
            valid_q   <= 1'b0;
            walk_en_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_RELEASE;
            valid_q   <= 1'b0;
            walk_en_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.phase_valid      = valid_q;
  assign bus.phase_select     = sel_q;
  assign bus.walk_enable      = walk_en_q;
  assign bus.pending_requests = eff_req;
  assign bus.phase_timeout    = timeout_q;

endmodule

// File: tb/tb_phase_request_scheduler.sv
module tb_phase_request_scheduler;

  localparam int TMAX = 8;
  localparam int NV   = 21;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  phase_request_scheduler_if bus();

  phase_request_scheduler #(.MAX_PHASE_CYCLES(TMAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] car;
    logic       ssb;
    logic       csb;
    logic       done;
    logic       valid;
    logic [1:0] sel;
    logic       wen;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[NV];

  // ---------------- reference model ----------------
  bit   mc[4];
  bit   mw[2];
  bit   mvalid, mwen, mto, mrel, m_was_active;
  int   msel, mage, mlast, mg, mp, m_was_sel;
  logic [3:0] tb_car;

  assign tb_car = {bus.cross_street_turn_lane_car_sensor, bus.cross_street_straight_lane_car_sensor,
                   bus.straight_street_turn_lane_car_sensor, bus.straight_street_straight_lane_car_sensor};

  function automatic bit m_eff(input int p);
    if (p == 0) return mc[0] | mw[0];
    if (p == 2) return mc[2] | mw[1];
    return mc[p];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 4; p++) mc[p] = 1'b0;
      mw[0] = 1'b0; mw[1] = 1'b0;
      mvalid = 1'b0; mwen = 1'b0; mto = 1'b0; mrel = 1'b0;
      msel = 0; mage = 0; mlast = 3;
    end else begin
      m_was_active = mvalid;
      m_was_sel    = msel;
      mg           = -1;
      if (mrel) begin
        mrel = 1'b0;
      end else if (mvalid) begin
        mage++;
        if (bus.phase_done) begin
          mvalid = 1'b0; mwen = 1'b0; mrel = 1'b1;
        end else if (mage == TMAX) begin
          mto = 1'b1; mvalid = 1'b0; mwen = 1'b0; mrel = 1'b1;
        end
      end else begin
        for (int off = 1; off <= 4; off++) begin
          mp = (mlast + off) % 4;
          if (mg < 0 && m_eff(mp)) mg = mp;
        end
        if (mg >= 0) begin
          mvalid = 1'b1;
          msel   = mg;
          mwen   = (mg == 0 && mw[0]) || (mg == 2 && mw[1]);
          mlast  = mg;
          mage   = 0;
        end
      end
      for (int p = 0; p < 4; p++)
        if (tb_car[p] && !(m_was_active && p == m_was_sel)) mc[p] = 1'b1;
      if (bus.straight_street_pedestrian_button && !(m_was_active && m_was_sel == 0)) mw[0] = 1'b1;
      if (bus.cross_street_pedestrian_button && !(m_was_active && m_was_sel == 2)) mw[1] = 1'b1;
      if (mg >= 0) begin
        mc[mg] = 1'b0;
        if (mg == 0) mw[0] = 1'b0;
        if (mg == 2) mw[1] = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [3:0] car, input logic ssb, input logic csb, input logic done);
    bus.straight_street_straight_lane_car_sensor = car[0];
    bus.straight_street_turn_lane_car_sensor     = car[1];
    bus.cross_street_straight_lane_car_sensor    = car[2];
    bus.cross_street_turn_lane_car_sensor        = car[3];
    bus.straight_street_pedestrian_button        = ssb;
    bus.cross_street_pedestrian_button           = csb;
    bus.phase_done                               = done;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(bus.phase_valid), 0);
    chk({tag, "_sel"},   int'(bus.phase_select), 0);
    chk({tag, "_wen"},   int'(bus.walk_enable), 0);
    chk({tag, "_pend"},  int'(bus.pending_requests), 0);
    chk({tag, "_tout"},  int'(bus.phase_timeout), 0);
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, int'(bus.phase_valid), int'(mvalid));
    chk({tag, "_wen"},   int'(bus.walk_enable), int'(mwen));
    chk({tag, "_pend"},  int'(bus.pending_requests), int'({mc[3], mc[2] | mw[1], mc[1], mc[0] | mw[0]}));
    chk({tag, "_tout"},  int'(bus.phase_timeout), int'(mto));
    if (mvalid) chk({tag, "_sel"}, int'(bus.phase_select), msel);
  endtask

  // ---------------- directed sequences ----------------
  task automatic seq_round_robin();
    int exp_order[5];
    int low;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      low = 0;
      while (!bus.phase_valid && low < 10) begin
        step();
        low++;
      end
      chk($sformatf("rr%0d_granted", n), int'(bus.phase_valid), 1);
      chk($sformatf("rr%0d_sel", n), int'(bus.phase_select), exp_order[n]);
      if (n > 0) chk($sformatf("rr%0d_gap", n), low, 2);
      repeat (4) step();
      drive(4'b1111, 1'b0, 1'b0, 1'b1);
      step();
      drive(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic seq_timeout();
    int hi;
    int early;
    do_reset();
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("to_granted", int'(bus.phase_valid), 1);
    hi = 0;
    early = 0;
    while (bus.phase_valid && hi < 20) begin
      if (bus.phase_timeout) early++;
      hi++;
      step();
    end
    chk("to_active_cycles", hi, TMAX);
    chk("to_early_flag", early, 0);
    chk("to_flag_release", int'(bus.phase_timeout), 1);
    step();
    chk("to_idle_valid", int'(bus.phase_valid), 0);
    chk("to_flag_idle", int'(bus.phase_timeout), 1);
    drive(4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("to_regrant_valid", int'(bus.phase_valid), 1);
    chk("to_regrant_sel", int'(bus.phase_select), 3);
    chk("to_flag_sticky", int'(bus.phase_timeout), 1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic seq_reset_mid();
    do_reset();
    drive(4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("rm_valid", int'(bus.phase_valid), 1);
    chk("rm_sel", int'(bus.phase_select), 2);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rm_pend", int'(bus.pending_requests), 4'b0001);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rm_async");
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("rm_post_valid", int'(bus.phase_valid), 1);
    chk("rm_post_sel", int'(bus.phase_select), 1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [3:0] rc;
    reset_n = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 1'b0);

    //           car      ssb   csb   done  valid sel   wen   pend
    vecs[0]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1000};
    vecs[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0010};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000};
    vecs[11] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[13] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100};
    vecs[14] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000};
    vecs[15] = '{4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[16] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0001};
    vecs[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001};
    vecs[18] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000};
    vecs[19] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[20] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].car, vecs[i].ssb, vecs[i].csb, vecs[i].done);
      step();
      chk($sformatf("vec%0d_valid", i), int'(bus.phase_valid), int'(vecs[i].valid));
      if (vecs[i].valid) chk($sformatf("vec%0d_sel", i), int'(bus.phase_select), int'(vecs[i].sel));
      chk($sformatf("vec%0d_wen", i), int'(bus.walk_enable), int'(vecs[i].wen));
      chk($sformatf("vec%0d_pend", i), int'(bus.pending_requests), int'(vecs[i].pend));
      chk($sformatf("vec%0d_tout", i), int'(bus.phase_timeout), 0);
    end
    drive(4'b0000, 1'b0, 1'b0, 1'b0);

    seq_round_robin();
    seq_timeout();
    seq_reset_mid();

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      check_model("rand");
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(399) == 0) reset_n = 1'b0;
      for (int k = 0; k < 4; k++) rc[k] = ($urandom_range(3) == 0);
      drive(rc, $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
      step();
    end
    check_model("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
